exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
Exception/interrupt controller directly upstream of the CP0 block in the single-cycle MIPS core. It gathers the synchronous trap requests from the decoder (SYSCALL, BREAK, TEQ) and the external interrupt lines, then applies the CP0 status masks and resolves priority. The winner drives CP0's exception/cause/eret inputs. A small handler-tracking state machine blocks any second exception until the matching ERET.

Parameters:
NIRQ, 6, number of external interrupt lines (1..6)
SYNC_STAGES, 2, flops in each irq synchronizer chain (>=2)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-low reset
syscall  input  1  decoded SYSCALL this cycle
brk  input  1  decoded BREAK this cycle
teq_trap  input  1  TEQ executed with equal operands this cycle
eret_req  input  1  decoded ERET this cycle
irq  input  NIRQ  external interrupt lines, asynchronous, rising-edge sensitive
status  input  32  CP0 status register value
exception  output  1  to CP0: take exception this cycle
cause  output  5  to CP0: exception code
eret  output  1  to CP0: return from exception this cycle
irq_pending  output  NIRQ  latched, not-yet-serviced interrupts
irq_id  output  3  index of the last interrupt taken
in_handler  output  1  handler active (state HANDLER)

Behaviour:
- Reset (rst=0, async): state=RUN; synchronizers, edge-history, irq_pending and irq_id are cleared to 0. exception=0, eret=0, in_handler=0, cause=0.
- Status fields: [0] global IE; [1] SYSCALL enable; [2] BREAK enable; [3] TEQ enable; [10+k] enable for irq[k].
- Cause codes: SYSCALL=5'b01000, BREAK=5'b01001, TEQ=5'b01101, INT=5'b00000.
- irq path: each line passes through a SYNC_STAGES flop chain, then a rising-edge detector.
  - A detected edge sets irq_pending[k] on the next clock.
  - Pending bits are sticky until that line is taken.
  - A new edge on a line already pending is merged, not counted.
- Exception decision is combinational in the same cycle as the request, because CP0 captures pc in that cycle. It is evaluated only when state=RUN and status[0]=1.
- Priority order:
  - syscall&status[1] first, then brk&status[2], then teq_trap&status[3].
  - Next, the highest k with irq_pending[k]&status[10+k] (cause=INT).
  - A masked synchronous request is dropped, not deferred.
  - Any enabled synchronous request blocks interrupts in that cycle.
- When exception=1, on that clock edge:
  - state goes to HANDLER.
  - If an interrupt won, irq_pending[k] clears and irq_id<=k.
  - An edge arriving on the same line in the same cycle re-sets the pending bit (set wins over clear).
- In HANDLER: exception is forced to 0; requests are ignored and irq edges keep latching.
- eret = eret_req & (state==HANDLER), combinational. On that edge state returns to RUN.
  - An eret_req in RUN is ignored (eret=0).
- Simultaneous eret_req and a new request in HANDLER: the ERET is taken and exception stays 0 that cycle. The pending interrupt may be taken on the next RUN cycle.
- cause holds its last driven value whenever exception=0.
- in_handler = (state==HANDLER).
- Reset asserted in HANDLER returns to RUN immediately and discards all pending interrupts.

Decomposition:
- Shared package (cp0_pkg): cause codes, status bit positions (IE, SYSCALL/BREAK/TEQ enables, IM base=10), state encoding RUN/HANDLER.
- One sub-module: irq_sync_edge, the per-line synchronizer plus rising-edge detector (instantiated NIRQ times).

Test Plan:
- Reset, then status=32'h0000_000F and syscall=1 for one cycle -> exception=1, cause=01000, in_handler=1 on the next cycle.
- In HANDLER, brk=1 -> exception=0. Then eret_req=1 -> eret=1, state RUN. Next, brk=1 -> cause=01001.
- status=32'h0000_0401 and irq[0] rises -> irq_pending[0]=1 after 3 clocks. Then exception=1, cause=00000, irq_id=0, and the pending bit clears.
- irq[0] and irq[3] pend with status=32'h0000_2401 -> irq[3] taken first (irq_id=3). After ERET, irq[0] is taken.
- syscall=1 with status=32'h0000_0001 -> exception=0. teq_trap=1 with a pending enabled irq and status=32'h0000_0409 -> cause=01101 and the irq stays pending.
- rst=0 asserted mid-HANDLER with irq_pending=6'b000101 -> all outputs 0 and state RUN asynchronously, before the next clock edge.

Source files
------------

// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_pkg
//  Description : Shared CP0 definitions for the exception controller:
//                exception cause codes, status register bit positions and
//                the handler-tracking state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cp0_pkg;

  // Exception codes presented to CP0 on the cause port
  localparam logic [4:0] c_cause_int     = 5'b00000;
  localparam logic [4:0] c_cause_syscall = 5'b01000;
  localparam logic [4:0] c_cause_break   = 5'b01001;
  localparam logic [4:0] c_cause_teq     = 5'b01101;

  // Status register bit positions
  localparam int c_st_ie      = 0;   // global interrupt/exception enable
  localparam int c_st_sys_en  = 1;   // SYSCALL enable
  localparam int c_st_brk_en  = 2;   // BREAK enable
  localparam int c_st_teq_en  = 3;   // TEQ trap enable
  localparam int c_st_im_base = 10;  // irq[k] enable lives at bit 10+k

  // Handler-tracking state
  typedef enum logic [0:0] {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } exc_state_e;

endpackage
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sync_edge
//  Description : Per-line synchronizer chain followed by a rising-edge
//                detector for one asynchronous interrupt input.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,        // asynchronous, active-low
  input  logic irq_async,
  output logic irq_edge
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the raw line through the chain; remember the last synchronized value
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_async};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge-history flops, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign irq_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : exc_ctrl
//  Description : Exception/interrupt controller feeding CP0. Collects the
//                decoder traps and external interrupts, applies the status
//                masks, resolves priority and blocks nested exceptions until
//                the matching ERET.
//  Revision    : 1.0 - initial release
// ============================================================================
module exc_ctrl
  import cp0_pkg::*;
#(
  parameter int NIRQ        = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,          // asynchronous, active-low
  input  logic            syscall,
  input  logic            brk,
  input  logic            teq_trap,
  input  logic            eret_req,
  input  logic [NIRQ-1:0] irq,
  input  logic [31:0]     status,
  output logic            exception,
  output logic [4:0]      cause,
  output logic            eret,
  output logic [NIRQ-1:0] irq_pending,
  output logic [2:0]      irq_id,
  output logic            in_handler
);

  exc_state_e      state_q, state_d;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic [2:0]      id_q, id_d;
  logic [4:0]      cause_q, cause_d;

  logic [NIRQ-1:0] irq_edge;
  logic [NIRQ-1:0] int_clr;
  logic            int_hit;
  logic [2:0]      int_idx;
  logic            take_exc;
  logic            take_int;
  logic            take_eret;
  logic [4:0]      cause_now;
  logic            unused_status_bits;

  // Only some status bits are meaningful here
  assign unused_status_bits = ^status;

  generate
    for (genvar k = 0; k < NIRQ; k++) begin : g_irq
      irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .irq_async (irq[k]),
        .irq_edge  (irq_edge[k])
      );
    end
  endgenerate

  // Priority resolution; combinational so CP0 captures the faulting pc this cycle.
  // Gated by rst so the outputs read 0 the moment reset asserts.
  always_comb begin
    int_hit   = 1'b0;
    int_idx   = 3'd0;
    take_exc  = 1'b0;
    take_int  = 1'b0;
    cause_now = cause_q;
    for (int k = 0; k < NIRQ; k++) begin
      if (pend_q[k] && status[c_st_im_base + k]) begin
        int_hit = 1'b1;
        int_idx = 3'(k);
      end
    end
    if (rst && (state_q == RUN) && status[c_st_ie]) begin
      if (syscall && status[c_st_sys_en]) begin
        take_exc  = 1'b1;
        cause_now = c_cause_syscall;
      end else if (brk && status[c_st_brk_en]) begin
        take_exc  = 1'b1;
        cause_now = c_cause_break;
      end else if (teq_trap && status[c_st_teq_en]) begin
        take_exc  = 1'b1;
        cause_now = c_cause_teq;
      end else if (int_hit) begin
        take_exc  = 1'b1;
        take_int  = 1'b1;
        cause_now = c_cause_int;
      end
    end
  end

  assign take_eret = rst & eret_req & (state_q == HANDLER);

  // Next-state: enter HANDLER on exception, leave on ERET, latch irq edges
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cause_d = cause_q;
    int_clr = '0;
    for (int k = 0; k < NIRQ; k++) begin
      if (take_int && (int_idx == 3'(k))) begin
        int_clr[k] = 1'b1;
      end
    end
    if (take_exc) begin
      state_d = HANDLER;
      cause_d = cause_now;
      if (take_int) begin
        id_d = int_idx;
      end
    end else if (take_eret) begin
      state_d = RUN;
    end
    // A fresh edge on the line being serviced re-arms it
    pend_d = (pend_q & ~int_clr) | irq_edge;
  end

  // Controller state flops, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pend_q  <= '0;
      id_q    <= 3'd0;
      cause_q <= 5'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      id_q    <= id_d;
      cause_q <= cause_d;
    end
  end

  assign exception   = take_exc;
  assign cause       = take_exc ? cause_now : cause_q;
  assign eret        = take_eret;
  assign irq_pending = pend_q;
  assign irq_id      = id_q;
  assign in_handler  = (state_q == HANDLER);

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exc_ctrl
//  Description : Scoreboard bench for exc_ctrl: directed scenarios followed
//                by random traffic, predicted by a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_ctrl;

  localparam int NIRQ = 6;
  localparam int SYNC = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            syscall, brk, teq_trap, eret_req;
  logic [NIRQ-1:0] irq;
  logic [31:0]     status;
  logic            exception, eret, in_handler;
  logic [4:0]      cause;
  logic [NIRQ-1:0] irq_pending;
  logic [2:0]      irq_id;

  exc_ctrl #(.NIRQ(NIRQ), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst         (rst),
    .syscall     (syscall),
    .brk         (brk),
    .teq_trap    (teq_trap),
    .eret_req    (eret_req),
    .irq         (irq),
    .status      (status),
    .exception   (exception),
    .cause       (cause),
    .eret        (eret),
    .irq_pending (irq_pending),
    .irq_id      (irq_id),
    .in_handler  (in_handler)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            exc;
    logic [4:0]      cause;
    logic            eret;
    logic            inh;
    logic [NIRQ-1:0] pend;
    logic [2:0]      id;
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  logic            m_handler;
  logic [NIRQ-1:0] m_pend;
  logic [2:0]      m_id;
  logic [4:0]      m_cause;
  logic [NIRQ-1:0] hist[$];   // hist[0] = irq sampled at the latest clock
  logic [NIRQ-1:0] irqv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_handler = 1'b0;
    m_pend    = '0;
    m_id      = 3'd0;
    m_cause   = 5'd0;
    hist.delete();
    for (int i = 0; i <= SYNC; i++) hist.push_back('0);
  endtask

  // One clock of stimulus: drive, predict, then advance the model
  task automatic step(input logic sc, input logic br, input logic tq, input logic er,
                      input logic [NIRQ-1:0] iq, input logic [31:0] st);
    exp_t            e;
    logic [NIRQ-1:0] edg;
    int              win;
    @(negedge clk);
    syscall = sc; brk = br; teq_trap = tq; eret_req = er; irq = iq; status = st;
    #1;
    // An edge is seen once a line is high after the chain but was low one clock earlier
    edg     = hist[SYNC-1] & ~hist[SYNC];
    win     = -1;
    e.exc   = 1'b0;
    e.cause = m_cause;
    e.eret  = er && m_handler;
    if (!m_handler && st[0]) begin
      if (sc && st[1])      begin e.exc = 1'b1; e.cause = 5'b01000; end
      else if (br && st[2]) begin e.exc = 1'b1; e.cause = 5'b01001; end
      else if (tq && st[3]) begin e.exc = 1'b1; e.cause = 5'b01101; end
      else begin
        for (int k = NIRQ - 1; k >= 0; k--)
          if (win < 0 && m_pend[k] && st[10 + k]) win = k;
        if (win >= 0) begin e.exc = 1'b1; e.cause = 5'b00000; end
      end
    end
    e.inh  = m_handler;
    e.pend = m_pend;
    e.id   = m_id;
    exp_q.push_back(e);
    @(posedge clk);
    hist.push_front(iq);
    void'(hist.pop_back());
    if (e.exc) begin
      m_handler = 1'b1;
      m_cause   = e.cause;
      if (win >= 0) begin
        m_pend[win] = 1'b0;
        m_id        = 3'(win);
      end
    end else if (e.eret) begin
      m_handler = 1'b0;
    end
    m_pend = m_pend | edg;
  endtask

  task automatic idle(input int n, input logic [31:0] st);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, irqv, st);
  endtask

  // Monitor: every cycle the DUT presents its outputs, pop and compare
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("exception",   {31'd0, exception}, {31'd0, e.exc});
        chk("cause",       {27'd0, cause},     {27'd0, e.cause});
        chk("eret",        {31'd0, eret},      {31'd0, e.eret});
        chk("in_handler",  {31'd0, in_handler},{31'd0, e.inh});
        chk("irq_pending", {26'd0, irq_pending}, {26'd0, e.pend});
        chk("irq_id",      {29'd0, irq_id},    {29'd0, e.id});
      end
    end
  end

  initial begin
    int budget;
    rst = 1'b0; syscall = 0; brk = 0; teq_trap = 0; eret_req = 0;
    irq = '0; status = '0; irqv = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_exception",  {31'd0, exception},  32'd0);
    chk("reset_in_handler", {31'd0, in_handler}, 32'd0);
    chk("reset_pending",    {26'd0, irq_pending}, 32'd0);
    rst = 1'b1;

    // SYSCALL taken, BREAK blocked in handler, ERET, then BREAK taken
    step(1, 0, 0, 0, irqv, 32'h0000_000F);
    #1 chk("tp_sys_in_handler", {31'd0, in_handler}, 32'd1);
    chk("tp_sys_cause_held", {27'd0, cause}, 32'h08);
    step(0, 1, 0, 0, irqv, 32'h0000_000F);
    step(0, 0, 0, 1, irqv, 32'h0000_000F);
    step(0, 1, 0, 0, irqv, 32'h0000_000F);
    #1 chk("tp_brk_cause", {27'd0, cause}, 32'h09);
    step(0, 0, 0, 1, irqv, 32'h0000_000F);
    step(0, 0, 0, 1, irqv, 32'h0000_000F);   // ERET in RUN is ignored

    // irq[0] rises with its mask enabled
    irqv = 6'b000001;
    idle(5, 32'h0000_0401);
    #1 chk("tp_irq0_id", {29'd0, irq_id}, 32'd0);
    chk("tp_irq0_in_handler", {31'd0, in_handler}, 32'd1);
    step(0, 0, 0, 1, irqv, 32'h0000_0401);
    irqv = 6'b000000;
    idle(3, 32'h0000_0401);

    // irq[0] and irq[3] pend with IE off, then irq[3] wins
    irqv = 6'b001001;
    idle(4, 32'h0000_2400);
    step(0, 0, 0, 0, irqv, 32'h0000_2401);
    #1 chk("tp_irq3_id", {29'd0, irq_id}, 32'd3);
    step(0, 0, 0, 1, irqv, 32'h0000_2401);
    step(0, 0, 0, 0, irqv, 32'h0000_2401);
    #1 chk("tp_irq0_after", {29'd0, irq_id}, 32'd0);
    step(0, 0, 0, 1, irqv, 32'h0000_2401);

    // Masked SYSCALL dropped; TEQ beats a pending enabled irq
    step(1, 0, 0, 0, irqv, 32'h0000_0001);
    irqv = 6'b000000;
    idle(3, 32'h0000_0408);
    irqv = 6'b000001;
    idle(4, 32'h0000_0408);
    step(0, 0, 1, 0, irqv, 32'h0000_0409);
    #1 chk("tp_teq_keeps_pending", {31'd0, irq_pending[0]}, 32'd1);
    step(0, 0, 0, 1, irqv, 32'h0000_0409);
    idle(2, 32'h0000_0409);
    step(0, 0, 0, 1, irqv, 32'h0000_0409);

    // Enter HANDLER with irq_pending=000101, then assert reset asynchronously
    irqv = 6'b000000;
    idle(3, 32'h0000_0000);
    irqv = 6'b000101;
    idle(4, 32'h0000_0000);
    step(1, 0, 0, 0, irqv, 32'h0000_0003);
    #1 chk("tp_pre_reset_pending", {26'd0, irq_pending}, 32'h05);
    @(negedge clk);
    #5 rst = 1'b0;
    #1;
    chk("async_exception",  {31'd0, exception},  32'd0);
    chk("async_eret",       {31'd0, eret},       32'd0);
    chk("async_in_handler", {31'd0, in_handler}, 32'd0);
    chk("async_pending",    {26'd0, irq_pending}, 32'd0);
    chk("async_cause",      {27'd0, cause},      32'd0);
    chk("async_irq_id",     {29'd0, irq_id},     32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] st;
      for (int k = 0; k < NIRQ; k++)
        if ($urandom_range(15) == 0) irqv[k] = ~irqv[k];
      st = ($urandom & 32'h0000_FC0E) | (($urandom_range(7) != 0) ? 32'd1 : 32'd0);
      step(($urandom_range(7) == 0), ($urandom_range(7) == 0), ($urandom_range(7) == 0),
           ($urandom_range(3) == 0), irqv, st);
    end

    budget = 5;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      #3;
      budget--;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
